// File: rtl/mapper_banked_gen_pkg.sv
// Shared slot definitions for the banked ROM mapper:
// bank-size modes, mapped window bounds and register-area prefix.
package mapper_banked_gen_pkg;

    typedef enum logic {
        BANK_8K,
        BANK_16K
    } bank_size_e;

    localparam logic [15:0] WIN_BASE   = 16'h4000;
    localparam logic [15:0] WIN_END    = 16'hC000;
    localparam logic [2:0]  REG_PREFIX = 3'b011;

endpackage

// File: rtl/mapper_wr_edge.sv
// Access edge detector: one pulse per rising strobe, and a strobe
// already high when reset releases never counts as a new access.
module mapper_wr_edge (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic pulse
);

    logic strobe_q, strobe_d;
    logic armed_q, armed_d;

    // Next state: remember last strobe, arm once strobe has been seen low.
    always_comb begin
        strobe_d = strobe;
        armed_d  = armed_q | ~strobe;
        pulse    = strobe & ~strobe_q & armed_q;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            strobe_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            armed_q  <= armed_d;
        end
    end

endmodule

// File: rtl/mapper_banked_gen.sv
// Generic banked ROM mapper for 0x4000-0xBFFF in 8 KB or 16 KB banks.
// Optional SRAM windows are compiled in with macro MAPPER_SRAM_EN.
module mapper_banked_gen
    import mapper_banked_gen_pkg::*;
#(
    parameter int          BANK_LOG2 = 13,
    parameter logic [7:0]  ROM_MASK  = 8'hFF,
    parameter int          SRAM_BIT  = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  din,
    input  logic        cpu_mreq,
    input  logic        cpu_wr,
    input  logic        cs,
    output logic [24:0] mem_addr,
    output logic        mem_unmaped
`ifdef MAPPER_SRAM_EN
    ,
    output logic        sram_cs,
    output logic [12:0] sram_addr,
    output logic        sram_we
`endif
);

    localparam int NBANK = (2 ** (16 - BANK_LOG2)) / 2;
    localparam int IDX_W = 15 - BANK_LOG2;

    localparam bank_size_e MODE =
        (BANK_LOG2 == 14) ? BANK_16K : BANK_8K;
    localparam int WR_SHIFT = (MODE == BANK_16K) ? 1 : 0;

    localparam logic [15:0] OFF_MASK =
        16'((32'd1 << BANK_LOG2) - 32'd1);

`ifdef MAPPER_SRAM_EN
    localparam logic [7:0] EFF_MASK =
        ROM_MASK & ~(8'd1 << SRAM_BIT);
`else
    localparam logic [7:0] EFF_MASK = ROM_MASK;
`endif

    if ((BANK_LOG2 != 13 && BANK_LOG2 != 14) ||
        SRAM_BIT < 0 || SRAM_BIT > 7) begin : g_bad_param
        $error("mapper_banked_gen: unsupported BANK_LOG2 or SRAM_BIT");
    end

    logic [7:0]       bank_q [NBANK];
    logic [7:0]       bank_d [NBANK];
    logic             wr_strobe;
    logic             wr_pulse;
    logic             in_win;
    logic             reg_hit;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       bank_m;

    mapper_wr_edge u_wr_edge (
        .clk    (clk),
        .reset  (reset),
        .strobe (wr_strobe),
        .pulse  (wr_pulse)
    );

    // Address decode and ROM address formation.
    always_comb begin
        wr_strobe   = cs & cpu_mreq & cpu_wr;
        in_win      = (cpu_addr >= WIN_BASE) && (cpu_addr < WIN_END);
        reg_hit     = (cpu_addr[15:13] == REG_PREFIX);
        rd_idx      = IDX_W'((cpu_addr - WIN_BASE) >> BANK_LOG2);
        wr_idx      = IDX_W'(cpu_addr[12:11] >> WR_SHIFT);
        bank_m      = bank_q[rd_idx] & EFF_MASK;
        mem_addr    = ({17'd0, bank_m} << BANK_LOG2)
                    | 25'(cpu_addr & OFF_MASK);
        mem_unmaped = cs & ~in_win;
    end

`ifdef MAPPER_SRAM_EN
    // SRAM select: flagged window, writes only in the upper half.
    always_comb begin
        sram_cs   = cs & cpu_mreq & in_win & bank_q[rd_idx][SRAM_BIT];
        sram_addr = cpu_addr[12:0];
        sram_we   = sram_cs & cpu_wr & cpu_addr[15] & ~reg_hit;
    end
`endif

    // Bank register next value: one update per detected access edge.
    always_comb begin
        bank_d = bank_q;
        if (wr_pulse && reg_hit) begin
            bank_d[wr_idx] = din;
        end
    end

    // Bank registers; reset maps window i to bank i.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NBANK; i++) begin
                bank_q[i] <= 8'(i);
            end
        end else begin
            bank_q <= bank_d;
        end
    end

endmodule

// File: tb/tb_mapper_banked_gen.sv
// Randomized bench for mapper_banked_gen: three configurations
// (8 KB, 8 KB masked, 16 KB) checked against an arithmetic model.
module tb_mapper_banked_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  din = 8'h0;
    logic        cpu_mreq = 1'b0;
    logic        cpu_wr = 1'b0;
    logic        cs = 1'b0;

    logic [24:0] ma [3];
    logic        unm [3];
`ifdef MAPPER_SRAM_EN
    logic        scs [3];
    logic [12:0] sad [3];
    logic        swe [3];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    int lg  [3] = '{13, 13, 14};
    int msk [3] = '{255, 15, 255};
    int bk  [3][4];

    always #5 clk = ~clk;

    mapper_banked_gen u_d8 (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .din(din),
        .cpu_mreq(cpu_mreq), .cpu_wr(cpu_wr), .cs(cs),
        .mem_addr(ma[0]), .mem_unmaped(unm[0])
`ifdef MAPPER_SRAM_EN
        , .sram_cs(scs[0]), .sram_addr(sad[0]), .sram_we(swe[0])
`endif
    );

    mapper_banked_gen #(.ROM_MASK(8'h0F)) u_m (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .din(din),
        .cpu_mreq(cpu_mreq), .cpu_wr(cpu_wr), .cs(cs),
        .mem_addr(ma[1]), .mem_unmaped(unm[1])
`ifdef MAPPER_SRAM_EN
        , .sram_cs(scs[1]), .sram_addr(sad[1]), .sram_we(swe[1])
`endif
    );

    mapper_banked_gen #(.BANK_LOG2(14)) u_d16 (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .din(din),
        .cpu_mreq(cpu_mreq), .cpu_wr(cpu_wr), .cs(cs),
        .mem_addr(ma[2]), .mem_unmaped(unm[2])
`ifdef MAPPER_SRAM_EN
        , .sram_cs(scs[2]), .sram_addr(sad[2]), .sram_we(swe[2])
`endif
    );

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++)
                bk[k][i] = i;
    endfunction

    function automatic void model_write(input int a, input int d);
        if ((a >> 13) == 3) begin
            for (int k = 0; k < 3; k++) begin
                if (lg[k] == 13) bk[k][(a >> 11) & 3] = d;
                else             bk[k][(a >> 12) & 1] = d;
            end
        end
    endfunction

    function automatic bit win_hit(input int a);
        return (a >= 'h4000) && (a < 'hC000);
    endfunction

    function automatic int exp_addr(input int k, input int a);
        int w, m;
        w = (a - 'h4000) / (1 << lg[k]);
        m = msk[k];
`ifdef MAPPER_SRAM_EN
        m = m & 'h7F;
`endif
        return (bk[k][w] & m) * (1 << lg[k]) + (a % (1 << lg[k]));
    endfunction

    task automatic check_access(input bit c, input int a, input bit w);
        @(negedge clk);
        cs = c; cpu_mreq = 1'b1; cpu_wr = w; cpu_addr = 16'(a);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("unm%0d@%h", k, a), 32'(unm[k]),
                     32'(c && !win_hit(a)));
            if (c && win_hit(a))
                check_eq($sformatf("ma%0d@%h", k, a), 32'(ma[k]),
                         32'(exp_addr(k, a)));
`ifdef MAPPER_SRAM_EN
            begin
                bit fl, ecs;
                fl  = 1'b0;
                if (win_hit(a))
                    fl = bk[k][(a - 'h4000) / (1 << lg[k])][7];
                ecs = c && win_hit(a) && fl;
                check_eq($sformatf("scs%0d@%h", k, a), 32'(scs[k]), 32'(ecs));
                check_eq($sformatf("swe%0d@%h", k, a), 32'(swe[k]),
                         32'(ecs && w && a >= 'h8000 && (a >> 13) != 3));
                check_eq($sformatf("sad%0d@%h", k, a), 32'(sad[k]),
                         32'(a & 'h1FFF));
            end
`endif
        end
    endtask

    task automatic do_write(input int a, input int d,
                            input int d2, input int hold);
        @(negedge clk);
        cs = 1'b0; cpu_mreq = 1'b0; cpu_wr = 1'b0;
        @(negedge clk);
        cpu_addr = 16'(a); din = 8'(d);
        cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1;
        @(posedge clk);
        #1 din = 8'(d2);
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        cs = 1'b0; cpu_mreq = 1'b0; cpu_wr = 1'b0;
        model_write(a, d);
    endtask

    task automatic check_all_windows();
        for (int i = 0; i < 4; i++)
            check_access(1'b1, 'h4000 + i * 'h2000 + $urandom_range(0, 'h1FFF), 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);

        // reset state and fixed reads after reset
        check_all_windows();
        check_access(1'b1, 'h6000, 1'b0);
        check_eq("r030_6000", 32'(ma[0]), 32'h02000);
        check_access(1'b1, 'hA123, 1'b0);
        check_eq("r030_A123", 32'(ma[0]), 32'h06123);

        // held write: din changes mid-hold must not be taken
        do_write('h7000, 'h15, 'h55, 5);
        check_access(1'b1, 'h8005, 1'b0);
        check_eq("r031_8005", 32'(ma[0]), 32'h2A005);

        // ROM_MASK wrap
        do_write('h6800, 'h3F, 'h3F, 1);
        check_access(1'b1, 'h6000, 1'b0);
        check_eq("r032_mask", 32'(ma[1]), 32'h1E000);

        // 16 KB mode and unmapped boundaries
        do_write('h7000, 'h03, 'h03, 2);
        check_access(1'b1, 'h8010, 1'b0);
        check_eq("r033_8010", 32'(ma[2]), 32'h0C010);
        check_access(1'b1, 'h3FFF, 1'b0);
        check_eq("r033_unm", 32'(unm[2]), 32'h1);
        check_access(1'b1, 'hC000, 1'b0);
        check_access(1'b1, 'hBFFF, 1'b0);
        check_access(1'b1, 'h4000, 1'b0);
        check_access(1'b0, 'h3FFF, 1'b0);

        // back-to-back writes to the same register: last one wins
        do_write('h6000, 'hA5, 'hA5, 1);
        do_write('h6000, 'h5A, 'h5A, 1);
        check_all_windows();

`ifdef MAPPER_SRAM_EN
        do_write('h7800, 'h80, 'h80, 1);
        check_access(1'b1, 'hA010, 1'b1);
        check_eq("r034_cs", 32'(scs[0]), 32'h1);
        check_eq("r034_we", 32'(swe[0]), 32'h1);
        check_eq("r034_addr", 32'(sad[0]), 32'h0010);
        do_write('h6000, 'h80, 'h80, 1);
        check_access(1'b1, 'h4010, 1'b1);
        check_eq("r034_cs0", 32'(scs[0]), 32'h1);
        check_eq("r034_we0", 32'(swe[0]), 32'h0);
`endif

        // randomized mix of register writes, ROM writes and reads
        for (int n = 0; n < 150; n++) begin
            int op, a;
            op = $urandom_range(0, 3);
            if (op == 0) begin
                a = 'h6000 | $urandom_range(0, 'h1FFF);
                do_write(a, $urandom_range(0, 255),
                         $urandom_range(0, 255), $urandom_range(1, 3));
            end else if (op == 1) begin
                a = $urandom_range(0, 'hFFFF);
                do_write(a, $urandom_range(0, 255),
                         $urandom_range(0, 255), $urandom_range(1, 3));
            end else begin
                bit w;
                a = $urandom_range(0, 'hFFFF);
                w = 1'($urandom_range(0, 1));
                if ((a >> 13) == 3) w = 1'b0;
                check_access(1'($urandom_range(0, 1)), a, w);
            end
        end

        // reset asserted in the same cycle as a write edge, strobe held
        @(negedge clk);
        cs = 1'b0; cpu_mreq = 1'b0; cpu_wr = 1'b0;
        @(negedge clk);
        cpu_addr = 16'h6000; din = 8'hEE;
        cs = 1'b1; cpu_mreq = 1'b1; cpu_wr = 1'b1;
        reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        cs = 1'b0; cpu_mreq = 1'b0; cpu_wr = 1'b0;
        model_reset();
        check_all_windows();
        check_access(1'b1, 'h4123, 1'b0);
        check_eq("r035_bank0", 32'(ma[0]), 32'h00123);

        // a fresh edge after reset still writes
        do_write('h6000, 'h21, 'h21, 1);
        check_all_windows();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
